// File: rtl/pc_reg_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg_irq_pkg
// Description : Shared types and helpers for the PC register / interrupt
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_reg_irq_pkg;

    // Sequencer states: normal fetch, vector-take cycle, handler running
    typedef enum logic [1:0] {
        PC_ST_RUN  = 2'd0,
        PC_ST_TAKE = 2'd1,
        PC_ST_ISR  = 2'd2
    } pc_state_e;

    localparam logic [31:0] c_PC_ALIGN_MASK = ~32'h0000_0003;

    // Instruction addresses are word aligned; drop the byte-offset bits
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & c_PC_ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_reg_irq_irq_pending.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg_irq_irq_pending
// Description : Per-line 2-flop synchronizer, rising-edge detect, sticky
//               pending bits, enable mask and fixed-priority encoder
//               (line 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg_irq_irq_pending
    import pc_reg_irq_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_d,
    input  logic [NUM_IRQ-1:0] i_clr,
    output logic               o_request,
    output logic [SEL_W-1:0]   o_sel
);

    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_active;
    logic [SEL_W-1:0]   w_sel;

    assign w_rise    = r_sync2 & ~r_sync_prev;
    assign w_active  = r_pending & r_mask;
    assign o_request = |w_active;
    assign o_sel     = w_sel;

    // Synchronize, edge-detect and accumulate requests; a new edge beats an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_prev <= '0;
            r_pending   <= '0;
            r_mask      <= '0;
        end else begin
            r_sync1     <= i_irq;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_pending   <= (r_pending & ~i_clr) | w_rise;
            if (i_mask_we) begin
                r_mask <= i_mask_d;
            end
        end
    end

    // Lowest-numbered enabled pending line wins
    always_comb begin
        w_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = i[SEL_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_reg_irq.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg_irq
// Description : Program-counter register with interrupt sequencer. Holds PC,
//               produces the interrupt vector and take/ack strobes, saves and
//               restores EPC around a single (non-nested) handler.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg_irq
    import pc_reg_irq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter int          VEC_SHIFT    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        i_next_pc,
    input  logic               i_stall,
    input  logic               i_eret,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_mask_we,
    input  logic [NUM_IRQ-1:0] i_mask_d,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_epc,
    output logic [31:0]        o_int_vec,
    output logic               o_int_take,
    output logic [NUM_IRQ-1:0] o_irq_ack,
    output logic               o_in_isr
);

    localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    pc_state_e          r_state;
    pc_state_e          w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_epc;
    logic [31:0]        r_int_vec;
    logic [SEL_W-1:0]   r_sel;
    logic               w_request;
    logic [SEL_W-1:0]   w_sel;
    logic [31:0]        w_vec;
    logic [31:0]        w_next_pc;

    assign w_next_pc = align_pc(i_next_pc);
    assign w_vec     = VEC_BASE + ({{(32-SEL_W){1'b0}}, w_sel} << VEC_SHIFT);

    assign o_pc      = r_pc;
    assign o_epc     = r_epc;
    assign o_int_vec = r_int_vec;

    pc_reg_irq_irq_pending #(
        .NUM_IRQ (NUM_IRQ),
        .SEL_W   (SEL_W)
    ) u_irq_pending (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_irq     (i_irq),
        .i_mask_we (i_mask_we),
        .i_mask_d  (i_mask_d),
        .i_clr     (o_irq_ack),
        .o_request (w_request),
        .o_sel     (w_sel)
    );

    // Sequencer state register, frozen while memory stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PC_ST_RUN;
        end else if (!i_stall) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and strobes; the ack only fires on an unstalled take cycle
    always_comb begin
        w_state_nxt = r_state;
        o_int_take  = 1'b0;
        o_in_isr    = 1'b0;
        o_irq_ack   = '0;
        case (r_state)
            PC_ST_RUN: begin
                if (w_request) begin
                    w_state_nxt = PC_ST_TAKE;
                end
            end
            PC_ST_TAKE: begin
                o_int_take  = 1'b1;
                w_state_nxt = PC_ST_ISR;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    o_irq_ack[i] = !i_stall && (r_sel == i[SEL_W-1:0]);
                end
            end
            PC_ST_ISR: begin
                o_in_isr = 1'b1;
                if (i_eret) begin
                    w_state_nxt = PC_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = PC_ST_RUN;
            end
        endcase
    end

    // PC / EPC / vector datapath; ERET only matters inside the handler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_VECTOR;
            r_epc     <= '0;
            r_int_vec <= VEC_BASE;
            r_sel     <= '0;
        end else if (!i_stall) begin
            case (r_state)
                PC_ST_RUN: begin
                    r_pc <= w_next_pc;
                    if (w_request) begin
                        r_sel     <= w_sel;
                        r_int_vec <= w_vec;
                    end
                end
                PC_ST_TAKE: begin
                    r_epc <= r_pc;
                    r_pc  <= w_next_pc;
                end
                PC_ST_ISR: begin
                    r_pc <= i_eret ? r_epc : w_next_pc;
                end
                default: begin
                    r_pc <= w_next_pc;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_reg_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_reg_irq
// Description : Directed self-checking bench for pc_reg_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_reg_irq;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        eret;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_d;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] int_vec;
    logic        int_take;
    logic [3:0]  irq_ack;
    logic        in_isr;

    int n_chk;
    int n_fail;

    pc_reg_irq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_next_pc  (next_pc),
        .i_stall    (stall),
        .i_eret     (eret),
        .i_irq      (irq),
        .i_mask_we  (mask_we),
        .i_mask_d   (mask_d),
        .o_pc       (pc),
        .o_epc      (epc),
        .o_int_vec  (int_vec),
        .o_int_take (int_take),
        .o_irq_ack  (irq_ack),
        .o_in_isr   (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        next_pc = 32'h0;
        stall   = 1'b0;
        eret    = 1'b0;
        irq     = 4'h0;
        mask_we = 1'b0;
        mask_d  = 4'h0;

        // ---- 1: reset ----
        tick(); tick();
        check("rst_pc",      pc,       32'h0);
        check("rst_epc",     epc,      32'h0);
        check("rst_vec",     int_vec,  32'h100);
        check("rst_take",    int_take, 0);
        check("rst_ack",     irq_ack,  0);
        check("rst_isr",     in_isr,   0);
        rst_n = 1'b1; next_pc = 32'h4;
        tick();
        check("t1_pc4",      pc,       32'h4);
        next_pc = 32'h8;
        tick();
        check("t1_pc8",      pc,       32'h8);
        #2 rst_n = 1'b0;
        #1 check("t1_async_rst", pc,   32'h0);
        tick();
        rst_n = 1'b1; next_pc = 32'h4;
        tick();
        check("t1_release",  pc,       32'h4);

        // ---- 2: single masked-in line, latency and vector ----
        mask_we = 1'b1; mask_d = 4'b0010; next_pc = 32'h40;
        tick();
        mask_we = 1'b0; irq[1] = 1'b1;
        tick(); tick(); tick();
        check("t2_no_take_e3", int_take, 0);
        tick();
        check("t2_take",     int_take, 1);
        check("t2_vec",      int_vec,  32'h110);
        check("t2_ack",      irq_ack,  4'b0010);
        check("t2_pc_take",  pc,       32'h40);
        next_pc = 32'h110;
        tick();
        check("t2_pc_isr",   pc,       32'h110);
        check("t2_epc",      epc,      32'h40);
        check("t2_in_isr",   in_isr,   1);
        check("t2_ack_off",  irq_ack,  0);
        irq[1] = 1'b0; next_pc = 32'h114; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t2_eret_pc",  pc,       32'h40);
        check("t2_eret_isr", in_isr,   0);

        // ---- 3: priority ----
        mask_we = 1'b1; mask_d = 4'hF; next_pc = 32'h80;
        tick();
        mask_we = 1'b0; irq = 4'b1001;
        tick(); tick(); tick(); tick();
        check("t3_take0",    int_take, 1);
        check("t3_vec0",     int_vec,  32'h100);
        check("t3_ack0",     irq_ack,  4'b0001);
        check("t3_pc_take",  pc,       32'h80);
        next_pc = 32'h100;
        tick();
        check("t3_epc0",     epc,      32'h80);
        check("t3_pc_isr",   pc,       32'h100);
        next_pc = 32'h104; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t3_eret_pc",  pc,       32'h80);
        check("t3_eret_isr", in_isr,   0);
        next_pc = 32'h84;
        tick();
        check("t3_take3",    int_take, 1);
        check("t3_vec3",     int_vec,  32'h130);
        check("t3_ack3",     irq_ack,  4'b1000);
        check("t3_pc_take3", pc,       32'h84);
        next_pc = 32'h130;
        tick();
        check("t3_epc3",     epc,      32'h84);
        next_pc = 32'h134; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t3_eret3_pc", pc,       32'h84);
        irq = 4'h0;

        // ---- 4: no nesting; ERET in RUN ignored ----
        next_pc = 32'h200; irq[1] = 1'b1;
        tick(); tick(); tick(); tick();
        check("t4_take1",    int_take, 1);
        check("t4_vec1",     int_vec,  32'h110);
        next_pc = 32'h110;
        tick();
        irq[2] = 1'b1; next_pc = 32'h114;
        repeat (5) tick();
        check("t4_no_nest",  int_take, 0);
        check("t4_in_isr",   in_isr,   1);
        check("t4_pc_isr",   pc,       32'h114);
        eret = 1'b1;
        tick();
        check("t4_eret_pc",  pc,       32'h200);
        check("t4_eret_isr", in_isr,   0);
        next_pc = 32'h204;
        tick();
        check("t4_run_eret_pc", pc,    32'h204);
        check("t4_take2",    int_take, 1);
        check("t4_vec2",     int_vec,  32'h120);
        check("t4_ack2",     irq_ack,  4'b0100);
        eret = 1'b0; next_pc = 32'h120;
        tick();
        check("t4_epc2",     epc,      32'h204);
        next_pc = 32'h124; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t4_eret2_pc", pc,       32'h204);
        irq = 4'h0;

        // ---- 5: stall during TAKE ----
        irq[0] = 1'b1; next_pc = 32'h300;
        tick(); tick(); tick(); tick();
        check("t5_take",     int_take, 1);
        check("t5_ack_pre",  irq_ack,  4'b0001);
        stall = 1'b1; next_pc = 32'h100;
        #1 check("t5_ack_stall_now", irq_ack, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_stall_pc",   pc,       32'h300);
            check("t5_stall_epc",  epc,      32'h204);
            check("t5_stall_take", int_take, 1);
            check("t5_stall_ack",  irq_ack,  0);
        end
        stall = 1'b0;
        #1 check("t5_ack_release", irq_ack, 4'b0001);
        tick();
        check("t5_pc_isr",   pc,       32'h100);
        check("t5_epc",      epc,      32'h300);
        check("t5_in_isr",   in_isr,   1);
        check("t5_ack_done", irq_ack,  0);
        next_pc = 32'h104; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t5_eret_pc",  pc,       32'h300);
        next_pc = 32'h304;
        tick(); tick();
        check("t5_no_retake", int_take, 0);
        irq = 4'h0;

        // ---- 6: masked pending line, alignment ----
        mask_we = 1'b1; mask_d = 4'b1110;
        tick();
        mask_we = 1'b0; irq[0] = 1'b1; next_pc = 32'h400;
        repeat (6) tick();
        check("t6_masked",   int_take, 0);
        check("t6_pc",       pc,       32'h400);
        mask_we = 1'b1; mask_d = 4'hF;
        tick();
        mask_we = 1'b0;
        check("t6_mask_lat", int_take, 0);
        tick();
        check("t6_take",     int_take, 1);
        check("t6_vec",      int_vec,  32'h100);
        check("t6_ack",      irq_ack,  4'b0001);
        next_pc = 32'h7;
        tick();
        check("t6_align",    pc,       32'h4);
        check("t6_epc",      epc,      32'h400);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t6_eret_pc",  pc,       32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
